// File: rtl/aha_sif_write_arbiter.sv
// aha_sif_write_arbiter: two-requester, burst-granular arbiter for the CGRA SIF write port.
// A granted burst owns the port until its last beat; SIF outputs are registered.
// Optional build macro AHA_SIF_ARB_FIXED_PRIO_EN: requester 0 always wins ties
// (default build: round-robin on ties).
module aha_sif_write_arbiter #(
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned DATA_WIDTH = 64,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    input  logic                  CMD0_VALID,
    output logic                  CMD0_READY,
    input  logic [ADDR_WIDTH-1:0] CMD0_ADDR,
    input  logic [7:0]            CMD0_LEN,
    input  logic                  CMD1_VALID,
    output logic                  CMD1_READY,
    input  logic [ADDR_WIDTH-1:0] CMD1_ADDR,
    input  logic [7:0]            CMD1_LEN,

    input  logic                  W0_VALID,
    output logic                  W0_READY,
    input  logic [DATA_WIDTH-1:0] W0_DATA,
    input  logic [STRB_WIDTH-1:0] W0_STRB,
    input  logic                  W1_VALID,
    output logic                  W1_READY,
    input  logic [DATA_WIDTH-1:0] W1_DATA,
    input  logic [STRB_WIDTH-1:0] W1_STRB,

    output logic [1:0]            DONE,
    output logic                  BUSY,
    output logic [ADDR_WIDTH-1:0] SIF_ADDR,
    output logic [STRB_WIDTH-1:0] SIF_STRB,
    output logic                  SIF_WE,
    output logic [DATA_WIDTH-1:0] SIF_DATA
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              cnt_q;

    logic                    winner_c;
    logic                    cmd_fire_c;
    logic                    w_fire_c;
    logic                    last_beat_c;
    logic [ADDR_WIDTH-1:0]   cmd_addr_c;
    logic [7:0]              cmd_len_c;
    logic [DATA_WIDTH-1:0]   w_data_c;
    logic [STRB_WIDTH-1:0]   w_strb_c;

`ifdef AHA_SIF_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        winner_c = ~CMD0_VALID;
    end
`else
    logic last_grant_q;

    // Round robin: on a tie the requester not granted last time wins.
    always_comb begin
        if (CMD0_VALID && CMD1_VALID) begin
            winner_c = ~last_grant_q;
        end else begin
            winner_c = CMD1_VALID;
        end
    end

    // Remember the most recent grant; reset value lets requester 0 win the first tie.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            last_grant_q <= 1'b1;
        end else if (cmd_fire_c) begin
            last_grant_q <= winner_c;
        end
    end
`endif

    // Command and write-beat muxes for the current winner / owner.
    always_comb begin
        cmd_addr_c = winner_c ? CMD1_ADDR : CMD0_ADDR;
        cmd_len_c  = winner_c ? CMD1_LEN  : CMD0_LEN;
        w_data_c   = grant_q  ? W1_DATA   : W0_DATA;
        w_strb_c   = grant_q  ? W1_STRB   : W0_STRB;
    end

    // Handshake detection.
    always_comb begin
        cmd_fire_c  = (CMD0_VALID && CMD0_READY) || (CMD1_VALID && CMD1_READY);
        w_fire_c    = grant_q ? (W1_VALID && W1_READY) : (W0_VALID && W0_READY);
        last_beat_c = w_fire_c && (cnt_q == 8'd0);
    end

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant on any command, release after the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire_c)  state_d = BURST;
            BURST:   if (last_beat_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: command ready only to the winner in IDLE, beat ready only to the owner in BURST.
    always_comb begin
        CMD0_READY = 1'b0;
        CMD1_READY = 1'b0;
        W0_READY   = 1'b0;
        W1_READY   = 1'b0;
        BUSY       = (state_q == BURST);
        if (!ARESET) begin
            case (state_q)
                IDLE: begin
                    CMD0_READY = CMD0_VALID && !winner_c;
                    CMD1_READY = CMD1_VALID &&  winner_c;
                end
                BURST: begin
                    W0_READY = !grant_q;
                    W1_READY =  grant_q;
                end
                default: ;
            endcase
        end
    end

    // Burst bookkeeping and registered SIF write port.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            grant_q  <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= 8'd0;
            SIF_WE   <= 1'b0;
            SIF_ADDR <= '0;
            SIF_STRB <= '0;
            SIF_DATA <= '0;
            DONE     <= 2'b00;
        end else begin
            SIF_WE <= w_fire_c;
            DONE   <= 2'b00;
            if (cmd_fire_c) begin
                addr_q  <= cmd_addr_c;
                cnt_q   <= cmd_len_c;
                grant_q <= winner_c;
            end
            if (w_fire_c) begin
                SIF_ADDR <= addr_q;
                SIF_DATA <= w_data_c;
                SIF_STRB <= w_strb_c;
                addr_q   <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
                cnt_q    <= cnt_q - 8'd1;
            end
            if (last_beat_c) begin
                DONE <= grant_q ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_aha_sif_write_arbiter.sv
// Bench for aha_sif_write_arbiter: burst table plus hand sequences for ties,
// ownership and reset mid-burst; SIF writes checked against a scoreboard queue.
module tb_aha_sif_write_arbiter;

    logic        clk = 1'b0;
    logic        ARESET;
    logic        CMD0_VALID, CMD0_READY, CMD1_VALID, CMD1_READY;
    logic [31:0] CMD0_ADDR, CMD1_ADDR;
    logic [7:0]  CMD0_LEN, CMD1_LEN;
    logic        W0_VALID, W0_READY, W1_VALID, W1_READY;
    logic [63:0] W0_DATA, W1_DATA;
    logic [7:0]  W0_STRB, W1_STRB;
    logic [1:0]  DONE;
    logic        BUSY;
    logic [31:0] SIF_ADDR;
    logic [7:0]  SIF_STRB;
    logic        SIF_WE;
    logic [63:0] SIF_DATA;

    aha_sif_write_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .ACLK(clk), .ARESET(ARESET),
        .CMD0_VALID(CMD0_VALID), .CMD0_READY(CMD0_READY), .CMD0_ADDR(CMD0_ADDR), .CMD0_LEN(CMD0_LEN),
        .CMD1_VALID(CMD1_VALID), .CMD1_READY(CMD1_READY), .CMD1_ADDR(CMD1_ADDR), .CMD1_LEN(CMD1_LEN),
        .W0_VALID(W0_VALID), .W0_READY(W0_READY), .W0_DATA(W0_DATA), .W0_STRB(W0_STRB),
        .W1_VALID(W1_VALID), .W1_READY(W1_READY), .W1_DATA(W1_DATA), .W1_STRB(W1_STRB),
        .DONE(DONE), .BUSY(BUSY), .SIF_ADDR(SIF_ADDR), .SIF_STRB(SIF_STRB),
        .SIF_WE(SIF_WE), .SIF_DATA(SIF_DATA)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  done;
    } exp_t;

    typedef struct {
        int          req;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  strb;
        bit          stall;
        logic [63:0] dbase;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[6];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic        rst_d = 1'b0;
    logic [31:0] last_addr = 32'd0;
    logic [63:0] last_data = 64'd0;
    logic [7:0]  last_strb = 8'd0;
    int          w2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset seen at the last rising edge clears the SIF model.
    always @(posedge clk) rst_d = ARESET;

    // SIF monitor: a queued beat must appear exactly one cycle after its handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        logic exp_we;
        if (rst_d) begin
            last_addr = 32'd0;
            last_data = 64'd0;
            last_strb = 8'd0;
            sbq.delete();
        end
        if (mon_en) begin
            exp_we = (sbq.size() != 0);
            chk("sif_we", 64'(SIF_WE), 64'(exp_we));
            if (exp_we) begin
                e = sbq.pop_front();
                last_addr = e.addr;
                last_data = e.data;
                last_strb = e.strb;
                chk("done", 64'(DONE), 64'(e.done));
            end else begin
                chk("done_idle", 64'(DONE), 64'd0);
            end
            chk("sif_addr", 64'(SIF_ADDR), 64'(last_addr));
            chk("sif_data", SIF_DATA, last_data);
            chk("sif_strb", 64'(SIF_STRB), 64'(last_strb));
        end
    end

    task automatic set_cmd(input int r, input logic v, input logic [31:0] a, input logic [7:0] l);
        if (r == 0) begin CMD0_VALID = v; CMD0_ADDR = a; CMD0_LEN = l; end
        else        begin CMD1_VALID = v; CMD1_ADDR = a; CMD1_LEN = l; end
    endtask

    task automatic set_w(input int r, input logic v, input logic [63:0] d, input logic [7:0] s);
        if (r == 0) begin W0_VALID = v; W0_DATA = d; W0_STRB = s; end
        else        begin W1_VALID = v; W1_DATA = d; W1_STRB = s; end
    endtask

    function automatic logic cmd_rdy(input int r);
        return (r == 0) ? CMD0_READY : CMD1_READY;
    endfunction

    function automatic logic w_rdy(input int r);
        return (r == 0) ? W0_READY : W1_READY;
    endfunction

    // Present a command from a negedge and wait (bounded) for acceptance.
    task automatic issue_cmd(input int r, input logic [31:0] a, input logic [7:0] l);
        int n;
        n = 0;
        set_cmd(r, 1'b1, a, l);
        #1;
        while (!cmd_rdy(r) && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("cmd_ready", 64'(cmd_rdy(r)), 64'd1);
        chk("w_ready_idle", 64'({W1_READY, W0_READY}), 64'd0);
        @(negedge clk);
        set_cmd(r, 1'b0, 32'd0, 8'd0);
    endtask

    // Drive beats of a granted burst, pushing each accepted beat to the scoreboard.
    task automatic send_beats(input int r, input logic [31:0] a, input logic [7:0] l,
                              input logic [7:0] s, input bit stall, input logic [63:0] db,
                              input int stop_after, input bit chk_other);
        int   k;
        int   cyc;
        logic v;
        exp_t e;
        k   = 0;
        cyc = 0;
        while (k <= int'(l) && k != stop_after && cyc < 600) begin
            v = stall ? (cyc % 2 == 0) : 1'b1;
            set_w(r, v, db + 64'(k), s);
            #1;
            chk("busy", 64'(BUSY), 64'd1);
            if (cyc == 0) chk("first_w_ready", 64'(w_rdy(r)), 64'd1);
            if (chk_other) chk("other_ready", 64'({cmd_rdy(1 - r), w_rdy(1 - r)}), 64'd0);
            if (v && w_rdy(r)) begin
                e.addr = a + 32'(k * 8);
                e.data = db + 64'(k);
                e.strb = s;
                e.done = (k == int'(l)) ? 2'(1 << r) : 2'b00;
                sbq.push_back(e);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        set_w(r, 1'b0, 64'd0, 8'd0);
        chk("beat_count", 64'(k), 64'((stop_after >= 0) ? stop_after : int'(l) + 1));
        if (stop_after < 0) begin
            #1;
            chk("busy_after", 64'(BUSY), 64'd0);
        end
    endtask

    // Both requesters present at once; w is the expected winner, the loser stays valid.
    task automatic tie_round(input logic [31:0] a0, input logic [31:0] a1, input int w);
        set_cmd(0, 1'b1, a0, 8'd1);
        set_cmd(1, 1'b1, a1, 8'd1);
        #1;
        chk("tie_cmd0_ready", 64'(CMD0_READY), 64'(w == 0));
        chk("tie_cmd1_ready", 64'(CMD1_READY), 64'(w == 1));
        @(negedge clk);
        set_cmd(w, 1'b0, 32'd0, 8'd0);
        send_beats(w, (w == 0) ? a0 : a1, 8'd1, 8'hFF, 1'b0,
                   (w == 0) ? 64'h20 : 64'h30, -1, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{req: 0, addr: 32'h0000_1000, len: 8'd3,   strb: 8'hFF, stall: 1'b0, dbase: 64'hA0};
        vecs[1] = '{req: 1, addr: 32'h0000_4000, len: 8'd2,   strb: 8'hFF, stall: 1'b1, dbase: 64'hB0};
        vecs[2] = '{req: 0, addr: 32'hFFFF_FFF8, len: 8'd1,   strb: 8'h0F, stall: 1'b0, dbase: 64'hC0};
        vecs[3] = '{req: 1, addr: 32'h0000_0100, len: 8'd0,   strb: 8'h00, stall: 1'b0, dbase: 64'hD0};
        vecs[4] = '{req: 0, addr: 32'h0000_8000, len: 8'd255, strb: 8'h5A, stall: 1'b0, dbase: 64'h1000};
        vecs[5] = '{req: 1, addr: 32'h0000_0020, len: 8'd4,   strb: 8'h81, stall: 1'b1, dbase: 64'hE0};

        ARESET = 1'b1;
        set_cmd(0, 1'b1, 32'h1234, 8'd0);
        set_cmd(1, 1'b0, 32'd0, 8'd0);
        set_w(0, 1'b0, 64'd0, 8'd0);
        set_w(1, 1'b0, 64'd0, 8'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd0_ready", 64'(CMD0_READY), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_sif_we", 64'(SIF_WE), 64'd0);
        chk("rst_sif_addr", 64'(SIF_ADDR), 64'd0);
        chk("rst_sif_data", SIF_DATA, 64'd0);
        chk("rst_sif_strb", 64'(SIF_STRB), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        ARESET = 1'b0;
        set_cmd(0, 1'b0, 32'd0, 8'd0);
        mon_en = 1'b1;
        @(negedge clk);

        // Ties: first goes to req0; second (req1 still pending) goes to req1 unless fixed priority.
`ifdef AHA_SIF_ARB_FIXED_PRIO_EN
        w2 = 0;
`else
        w2 = 1;
`endif
        tie_round(32'h2000, 32'h3000, 0);
        tie_round(32'h2100, 32'h3000, w2);
        if (w2 == 0) begin
            issue_cmd(1, 32'h3000, 8'd1);
            send_beats(1, 32'h3000, 8'd1, 8'hFF, 1'b0, 64'h30, -1, 1'b0);
        end else begin
            issue_cmd(0, 32'h2100, 8'd1);
            send_beats(0, 32'h2100, 8'd1, 8'hFF, 1'b0, 64'h20, -1, 1'b0);
        end

        // Table of single bursts.
        for (int i = 0; i < 6; i++) begin
            issue_cmd(vecs[i].req, vecs[i].addr, vecs[i].len);
            send_beats(vecs[i].req, vecs[i].addr, vecs[i].len, vecs[i].strb,
                       vecs[i].stall, vecs[i].dbase, -1, 1'b0);
        end

        // Ownership: req1 pushes command and beats while req0 owns the port.
        set_cmd(1, 1'b1, 32'h7000, 8'd0);
        set_w(1, 1'b1, 64'hDEAD, 8'hFF);
        issue_cmd(0, 32'h9000, 8'd3);
        send_beats(0, 32'h9000, 8'd3, 8'hFF, 1'b0, 64'h90, -1, 1'b1);
        chk("own_cmd1_ready", 64'(CMD1_READY), 64'd1);
        issue_cmd(1, 32'h7000, 8'd0);
        send_beats(1, 32'h7000, 8'd0, 8'hFF, 1'b0, 64'h70, -1, 1'b0);

        // Reset after 2 of 5 beats; the burst is abandoned without DONE.
        issue_cmd(0, 32'h5000, 8'd4);
        send_beats(0, 32'h5000, 8'd4, 8'hFF, 1'b0, 64'h50, 2, 1'b0);
        ARESET = 1'b1;
        set_w(0, 1'b1, 64'h55, 8'hFF);
        #1;
        chk("rst_w0_ready", 64'(W0_READY), 64'd0);
        @(negedge clk);
        ARESET = 1'b0;
        set_w(0, 1'b0, 64'd0, 8'd0);
        #1;
        chk("rst_mid_busy", 64'(BUSY), 64'd0);
        chk("rst_mid_done", 64'(DONE), 64'd0);
        chk("rst_mid_we", 64'(SIF_WE), 64'd0);
        issue_cmd(0, 32'h6000, 8'd1);
        send_beats(0, 32'h6000, 8'd1, 8'hFF, 1'b0, 64'h60, -1, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
